gerenciador_estabelecidos_mp: RTL and testbench

Multi-port store of per-node "established" flags/tags for the path-search datapath. It is the next generation of the established-node manager: NUM_RD parameterised read ports with registered data and valid outputs, and one write port. A sequenced clear sweep replaces the whole-array asynchronous clear, so the array can map to RAM. A live count of nonzero entries lets the search controller detect "all nodes established" without scanning.

---
 rtl/gerenciador_estabelecidos_mp.sv | 104 ++++++++++
 tb/tb_gerenciador_estabelecidos_mp.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gerenciador_estabelecidos_mp.sv
// Multi-port store of per-node established flags with sequenced clear sweep,
// registered read ports, write-first bypass and a live nonzero-entry count.
module gerenciador_estabelecidos_mp #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_in,
  output logic                         busy_out,
  input  logic                         write_en_in,
  input  logic [ADDR_WIDTH-1:0]        write_addr_in,
  input  logic [DATA_WIDTH-1:0]        write_data_in,
  input  logic [NUM_RD-1:0]            read_en_in,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] read_addr_in,
  output logic [NUM_RD*DATA_WIDTH-1:0] read_data_out,
  output logic [NUM_RD-1:0]            read_valid_out,
  output logic [ADDR_WIDTH:0]          count_out
);

  localparam int MEM_SIZE = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] old_data;
  logic                  wr_accept;
  logic [DATA_WIDTH-1:0] rd_word [NUM_RD];

  // Clear has priority over a write presented in the same IDLE cycle.
  assign wr_accept = (state == IDLE) && write_en_in && !clear_in;
  assign old_data  = mem[write_addr_in];

  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[sweep_addr] <= '0;
    else if (wr_accept)
      mem[write_addr_in] <= write_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      sweep_addr <= '0;
      busy_out   <= 1'b1;
      count_out  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (sweep_addr == LAST_ADDR) begin
            state      <= IDLE;
            busy_out   <= 1'b0;
            sweep_addr <= '0;
          end else begin
            sweep_addr <= sweep_addr + ADDR_ONE;
          end
        end
        default: begin
          if (clear_in) begin
            state     <= CLEAR;
            busy_out  <= 1'b1;
            count_out <= '0;
          end else if (write_en_in) begin
            if (old_data == '0 && write_data_in != '0)
              count_out <= count_out + CNT_ONE;
            else if (old_data != '0 && write_data_in == '0)
              count_out <= count_out - CNT_ONE;
          end
        end
      endcase
    end
  end

  // Array reads as empty during a sweep; same-address writes bypass to readers.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_word[k] = mem[read_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH]];
      if (state == CLEAR)
        rd_word[k] = '0;
      else if (wr_accept && write_addr_in == read_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH])
        rd_word[k] = write_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_out  <= '0;
      read_valid_out <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        read_valid_out[k] <= read_en_in[k];
        if (read_en_in[k])
          read_data_out[k*DATA_WIDTH +: DATA_WIDTH] <= rd_word[k];
      end
    end
  end

endmodule

// File: tb/tb_gerenciador_estabelecidos_mp.sv
// Randomized and directed bench for gerenciador_estabelecidos_mp against an
// array-based reference model of the store, its clear sweep and its count.
module tb_gerenciador_estabelecidos_mp;
  localparam int DW = 4;
  localparam int AW = 8;
  localparam int NR = 4;
  localparam int MS = 256;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clr = 1'b0;
  logic           busy;
  logic           we = 1'b0;
  logic [AW-1:0]  waddr = '0;
  logic [DW-1:0]  wdata = '0;
  logic [NR-1:0]  ren = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]  rvalid;
  logic [AW:0]    count;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]  model [MS];
  int             remaining;
  logic [NR*DW-1:0] exp_data;
  logic [NR-1:0]  exp_valid;

  gerenciador_estabelecidos_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst_n(rst_n), .clear_in(clr), .busy_out(busy),
    .write_en_in(we), .write_addr_in(waddr), .write_data_in(wdata),
    .read_en_in(ren), .read_addr_in(raddr), .read_data_out(rdata),
    .read_valid_out(rvalid), .count_out(count)
  );

  always #5 clk = ~clk;

  function automatic int exp_count();
    int n = 0;
    for (int a = 0; a < MS; a++) if (model[a] != '0) n++;
    return n;
  endfunction

  function automatic logic exp_busy();
    return remaining > 0;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < MS; a++) model[a] = '0;
    remaining = MS;
    exp_data  = '0;
    exp_valid = '0;
  endtask

  // Advance one edge, evolving the model from the inputs seen at that edge.
  task automatic tick();
    logic [AW-1:0] ra;
    @(posedge clk);
    exp_valid = ren;
    for (int k = 0; k < NR; k++) begin
      ra = raddr[k*AW +: AW];
      if (ren[k]) begin
        if (remaining > 0)                   exp_data[k*DW +: DW] = '0;
        else if (we && !clr && waddr == ra)  exp_data[k*DW +: DW] = wdata;
        else                                 exp_data[k*DW +: DW] = model[ra];
      end
    end
    if (remaining > 0) remaining--;
    else if (clr) begin
      for (int a = 0; a < MS; a++) model[a] = '0;
      remaining = MS;
    end else if (we) model[waddr] = wdata;
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; we = 1'b0; ren = '0;
  endtask

  task automatic do_write(input int a, input int d);
    we = 1'b1; waddr = AW'(a); wdata = DW'(d);
    tick();
    idle_inputs();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 600) begin tick(); n++; end
    checks++;
    if (n != MS) begin
      errors++;
      $display("FAIL %s busy_len actual=%0d required=%0d", name, n, MS);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b1 || count !== '0 || rvalid !== '0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_state actual busy=%b count=%0d valid=%b data=%h required 1/0/0/0",
               busy, count, rvalid, rdata);
    end
    rst_n = 1'b1;
    model_reset();
    wait_idle("reset_sweep");
    for (int a = 0; a < MS; a++) begin
      ren = '1;
      for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = AW'(a);
      tick();
      checks++;
      if (rvalid !== 4'hF || rdata !== '0) begin
        errors++;
        $display("FAIL reset_read addr=%0d actual valid=%b data=%h required F/0", a, rvalid, rdata);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (rvalid !== '0 || count !== '0) begin
      errors++;
      $display("FAIL reset_after actual valid=%b count=%0d required 0/0", rvalid, count);
    end
  endtask

  task automatic test_write_read();
    do_write(5, 1);
    checks++;
    if (count !== 9'd1) begin
      errors++;
      $display("FAIL wr5_count actual=%0d required=1", count);
    end
    ren = 4'b0010; raddr[1*AW +: AW] = 8'd5;
    tick();
    idle_inputs();
    checks++;
    if (rvalid[1] !== 1'b1 || rdata[1*DW +: DW] !== 4'd1) begin
      errors++;
      $display("FAIL rd5_port1 actual valid=%b data=%0d required 1/1", rvalid[1], rdata[1*DW +: DW]);
    end
  endtask

  task automatic test_bypass();
    int c0;
    we = 1'b1; waddr = 8'd7; wdata = 4'd1;
    ren = 4'b0001; raddr[0 +: AW] = 8'd7;
    tick();
    idle_inputs();
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[0 +: DW] !== 4'd1) begin
      errors++;
      $display("FAIL bypass7 actual valid=%b data=%0d required 1/1", rvalid[0], rdata[0 +: DW]);
    end
    c0 = exp_count();
    do_write(7, 1);
    checks++;
    if (int'(count) != c0) begin
      errors++;
      $display("FAIL rewrite7_count actual=%0d required=%0d", count, c0);
    end
    do_write(7, 0);
    checks++;
    if (int'(count) != c0 - 1) begin
      errors++;
      $display("FAIL zero7_count actual=%0d required=%0d", count, c0 - 1);
    end
  endtask

  task automatic test_clear();
    int n = 0;
    do_write(1, 1); do_write(2, 1); do_write(3, 1);
    clr = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (busy !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL clear_start actual busy=%b count=%0d required 1/0", busy, count);
    end
    while (busy && n < 600) begin
      we  = (n == 10);  waddr = 8'd9; wdata = 4'd5;
      clr = (n == 99);
      tick();
      n++;
      idle_inputs();
    end
    checks++;
    if (n != MS) begin
      errors++;
      $display("FAIL clear_len actual=%0d required=%0d", n, MS);
    end
    ren = 4'b0100; raddr[2*AW +: AW] = 8'd9;
    tick();
    idle_inputs();
    checks++;
    if (rdata[2*DW +: DW] !== 4'd0 || count !== '0) begin
      errors++;
      $display("FAIL clear_drop9 actual data=%0d count=%0d required 0/0", rdata[2*DW +: DW], count);
    end
  endtask

  task automatic test_clear_write_same();
    clr = 1'b1; we = 1'b1; waddr = 8'd4; wdata = 4'd1;
    tick();
    idle_inputs();
    wait_idle("clrwr_sweep");
    ren = 4'b1000; raddr[3*AW +: AW] = 8'd4;
    tick();
    idle_inputs();
    checks++;
    if (rdata[3*DW +: DW] !== 4'd0 || count !== '0) begin
      errors++;
      $display("FAIL clrwr_addr4 actual data=%0d count=%0d required 0/0", rdata[3*DW +: DW], count);
    end
  endtask

  task automatic test_multiport();
    logic [NR*DW-1:0] want;
    do_write(10, 3); do_write(20, 6); do_write(30, 9); do_write(40, 12);
    checks++;
    if (count !== 9'd4) begin
      errors++;
      $display("FAIL mp_count actual=%0d required=4", count);
    end
    ren = '1;
    raddr = {8'd40, 8'd30, 8'd20, 8'd10};
    tick();
    idle_inputs();
    want = {4'd12, 4'd9, 4'd6, 4'd3};
    checks++;
    if (rvalid !== 4'hF || rdata !== want) begin
      errors++;
      $display("FAIL mp_read actual valid=%b data=%h required F/%h", rvalid, rdata, want);
    end
    clr = 1'b1;
    tick();
    idle_inputs();
    repeat (50) tick();
    rst_n = 1'b0;
    #20;
    rst_n = 1'b1;
    model_reset();
    wait_idle("mp_reset_sweep");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      clr = ($urandom_range(0, 99) == 0);
      we  = $urandom_range(0, 1);
      waddr = AW'($urandom_range(0, 15));
      wdata = ($urandom_range(0, 2) == 0) ? 4'd0 : DW'($urandom);
      ren = NR'($urandom);
      for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = AW'($urandom_range(0, 15));
      tick();
      checks++;
      if (busy !== exp_busy() || int'(count) != exp_count() ||
          rvalid !== exp_valid || rdata !== exp_data) begin
        errors++;
        $display("FAIL random cyc=%0d actual busy=%b count=%0d valid=%b data=%h required %b/%0d/%b/%h",
                 i, busy, count, rvalid, rdata, exp_busy(), exp_count(), exp_valid, exp_data);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_clear_write_same();
    test_multiport();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
